// File: rtl/ysyx_24100006_lsu_if.sv
// EXU/WBU/memory bundle of the load/store unit; slave = LSU side, master = environment side.
// out_fault is present only when LSU_ALIGN_CHECK_EN is defined.
interface ysyx_24100006_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_func3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        in_reg_wen;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_wen;
`ifdef LSU_ALIGN_CHECK_EN
    logic        out_fault;
`endif
    logic        Mem_Write;
    logic [7:0]  Mem_WMask;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        Mem_Read;
    logic [31:0] raddr;
    logic [31:0] rdata;

    modport slave (
        input  in_valid, in_mem_read, in_mem_write, in_func3, in_addr, in_wdata,
               in_rd, in_reg_wen, out_ready, rdata,
`ifdef LSU_ALIGN_CHECK_EN
        output out_fault,
`endif
        output in_ready, out_valid, out_result, out_rd, out_reg_wen,
               Mem_Write, Mem_WMask, waddr, wdata, Mem_Read, raddr
    );

    modport master (
        output in_valid, in_mem_read, in_mem_write, in_func3, in_addr, in_wdata,
               in_rd, in_reg_wen, out_ready, rdata,
`ifdef LSU_ALIGN_CHECK_EN
        input  out_fault,
`endif
        input  in_ready, out_valid, out_result, out_rd, out_reg_wen,
               Mem_Write, Mem_WMask, waddr, wdata, Mem_Read, raddr
    );
endinterface

// File: rtl/ysyx_24100006_lsu.sv
// Load/store unit: IDLE -> [WAIT] -> ACCESS -> DONE, one memory strobe per op.
// Optional LSU_ALIGN_CHECK_EN: misaligned half/word ops fault instead of accessing memory.
module ysyx_24100006_lsu #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ysyx_24100006_lsu_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

    state_t      r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic        r_read, r_write, r_reg_wen;
    logic [2:0]  r_func3;
    logic [31:0] r_addr, r_wdata, r_result;
    logic [7:0]  r_mask;
    logic [4:0]  r_rd;

    logic        w_accept, w_mem, w_is_half, w_is_word, w_misalign;
    logic [3:0]  w_mask4;
    logic [31:0] w_lsh, w_load;

    assign w_accept  = bus.in_valid && (r_state == S_IDLE);
    assign w_mem     = bus.in_mem_read || bus.in_mem_write;
    assign w_is_half = (bus.in_func3[1:0] == 2'b01);
    assign w_is_word = bus.in_func3[1];

`ifdef LSU_ALIGN_CHECK_EN
    logic r_fault;
    assign w_misalign = w_mem && ((w_is_half && bus.in_addr[0]) ||
                                  (w_is_word && (bus.in_addr[1:0] != 2'b00)));
    assign bus.out_fault = r_fault;
`else
    assign w_misalign = 1'b0;
`endif

    // 4-bit shift drops lanes past byte 3 for unaligned halfwords
    assign w_mask4 = w_is_word ? 4'hF :
                     w_is_half ? (4'b0011 << bus.in_addr[1:0]) :
                                 (4'b0001 << bus.in_addr[1:0]);

    assign w_lsh = bus.rdata >> {r_addr[1:0], 3'b000};
    always_comb begin
        w_load = w_lsh;
        case (r_func3)
            3'b000:  w_load = {{24{w_lsh[7]}},  w_lsh[7:0]};
            3'b001:  w_load = {{16{w_lsh[15]}}, w_lsh[15:0]};
            3'b100:  w_load = {24'h0, w_lsh[7:0]};
            3'b101:  w_load = {16'h0, w_lsh[15:0]};
            default: w_load = w_lsh;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (w_mem && !w_misalign) w_next = (MEM_LAT == 0) ? S_ACCESS : S_WAIT;
                else                      w_next = S_DONE;
            end
            S_WAIT:   if (r_cnt == LAT_LAST) w_next = S_ACCESS;
            S_ACCESS: w_next = S_DONE;
            S_DONE:   if (bus.out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_reg_wen <= 1'b0;
            r_func3   <= 3'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_result  <= 32'h0;
            r_mask    <= 8'h0;
            r_rd      <= 5'h0;
`ifdef LSU_ALIGN_CHECK_EN
            r_fault   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    // write wins when both read and write are set
                    r_write   <= bus.in_mem_write && !w_misalign;
                    r_read    <= bus.in_mem_read && !bus.in_mem_write && !w_misalign;
                    r_reg_wen <= bus.in_reg_wen && !bus.in_mem_write && !w_misalign;
                    r_func3   <= bus.in_func3;
                    r_addr    <= bus.in_addr;
                    r_wdata   <= bus.in_wdata << {bus.in_addr[1:0], 3'b000};
                    r_mask    <= (bus.in_mem_write && !w_misalign) ? {4'h0, w_mask4} : 8'h0;
                    r_rd      <= bus.in_rd;
                    r_result  <= bus.in_addr;
                    r_cnt     <= '0;
`ifdef LSU_ALIGN_CHECK_EN
                    r_fault   <= w_misalign;
`endif
                end
                S_WAIT:   r_cnt <= (r_cnt == LAT_LAST) ? '0 : r_cnt + 1'b1;
                S_ACCESS: if (r_read) r_result <= w_load;
                default:  ;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = (r_state == S_DONE);
    assign bus.out_result  = r_result;
    assign bus.out_rd      = r_rd;
    assign bus.out_reg_wen = r_reg_wen;
    assign bus.Mem_Write   = (r_state == S_ACCESS) && r_write;
    assign bus.Mem_Read    = (r_state == S_ACCESS) && r_read;
    assign bus.Mem_WMask   = r_mask;
    assign bus.waddr       = r_addr;
    assign bus.raddr       = r_addr;
    assign bus.wdata       = r_wdata;
endmodule

// File: tb/tb_ysyx_24100006_lsu.sv
// Directed bench for ysyx_24100006_lsu: MEM_LAT=1 instance for the main tests,
// MEM_LAT=3 instance for latency and mid-WAIT reset.
module tb_ysyx_24100006_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst3_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ysyx_24100006_lsu_if bus ();
    ysyx_24100006_lsu_if bus3 ();

    ysyx_24100006_lsu #(.MEM_LAT(1), .CNT_W(4)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
    ysyx_24100006_lsu #(.MEM_LAT(3), .CNT_W(4)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(bus3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic wen);
        bus.in_valid     = 1'b1;
        bus.in_mem_read  = rd;
        bus.in_mem_write = wr;
        bus.in_func3     = f3;
        bus.in_addr      = addr;
        bus.in_wdata     = wd;
        bus.in_rd        = 5'd9;
        bus.in_reg_wen   = wen;
    endtask

    task automatic retire(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ".idle_valid"}, {31'h0, bus.out_valid}, 32'h0);
        chk({tag, ".idle_ready"}, {31'h0, bus.in_ready}, 32'h1);
    endtask

    task automatic store(input string tag, input logic rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [7:0] mask, input logic [31:0] wd);
        drive(rd, 1'b1, f3, addr, rs2, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk({tag, ".wr+1"}, {31'h0, bus.Mem_Write}, 32'h0);
        tick();
        chk({tag, ".wr+2"}, {31'h0, bus.Mem_Write}, 32'h1);
        chk({tag, ".rd+2"}, {31'h0, bus.Mem_Read}, 32'h0);
        chk({tag, ".mask"}, {24'h0, bus.Mem_WMask}, {24'h0, mask});
        chk({tag, ".wdata"}, bus.wdata, wd);
        chk({tag, ".waddr"}, bus.waddr, addr);
        tick();
        chk({tag, ".wr+3"}, {31'h0, bus.Mem_Write}, 32'h0);
        chk({tag, ".valid+3"}, {31'h0, bus.out_valid}, 32'h1);
        chk({tag, ".reg_wen"}, {31'h0, bus.out_reg_wen}, 32'h0);
        retire(tag);
    endtask

    task automatic load(input string tag, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] res);
        drive(1'b1, 1'b0, f3, addr, 32'h0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk({tag, ".rd+1"}, {31'h0, bus.Mem_Read}, 32'h0);
        tick();
        chk({tag, ".rd+2"}, {31'h0, bus.Mem_Read}, 32'h1);
        chk({tag, ".raddr"}, bus.raddr, addr);
        tick();
        chk({tag, ".valid+3"}, {31'h0, bus.out_valid}, 32'h1);
        chk({tag, ".result"}, bus.out_result, res);
        chk({tag, ".reg_wen"}, {31'h0, bus.out_reg_wen}, 32'h1);
        chk({tag, ".out_rd"}, {27'h0, bus.out_rd}, 32'd9);
        retire(tag);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_mem_read = 1'b0; bus.in_mem_write = 1'b0;
        bus.in_func3 = 3'b0; bus.in_addr = 32'h0; bus.in_wdata = 32'h0;
        bus.in_rd = 5'h0; bus.in_reg_wen = 1'b0; bus.out_ready = 1'b0;
        bus.rdata = 32'h12F45678;
        bus3.in_valid = 1'b0; bus3.in_mem_read = 1'b0; bus3.in_mem_write = 1'b0;
        bus3.in_func3 = 3'b0; bus3.in_addr = 32'h0; bus3.in_wdata = 32'h0;
        bus3.in_rd = 5'h0; bus3.in_reg_wen = 1'b0; bus3.out_ready = 1'b0;
        bus3.rdata = 32'h12F45678;

        tick();
        chk("rst.in_ready",  {31'h0, bus.in_ready},    32'h1);
        chk("rst.out_valid", {31'h0, bus.out_valid},   32'h0);
        chk("rst.strobes",   {30'h0, bus.Mem_Write, bus.Mem_Read}, 32'h0);
        chk("rst.mask",      {24'h0, bus.Mem_WMask},   32'h0);
        chk("rst.addr",      bus.waddr | bus.raddr,    32'h0);
        chk("rst.wdata",     bus.wdata,                32'h0);
        chk("rst.result",    bus.out_result,           32'h0);
        chk("rst.rd_wen",    {26'h0, bus.out_rd, bus.out_reg_wen}, 32'h0);
        rst_n = 1'b1; rst3_n = 1'b1;
        tick();

        store("sw",  1'b0, 3'b010, 32'h80000004, 32'hDEADBEEF, 8'h0F, 32'hDEADBEEF);
        store("sb3", 1'b0, 3'b000, 32'h80000003, 32'h000000AB, 8'h08, 32'hAB000000);
        store("sh2", 1'b0, 3'b001, 32'h80000002, 32'h00001234, 8'h0C, 32'h12340000);
        store("sb1", 1'b0, 3'b000, 32'h80000001, 32'h000000CD, 8'h02, 32'h0000CD00);
        store("rw",  1'b1, 3'b010, 32'h80000008, 32'h01020304, 8'h0F, 32'h01020304);

        load("lb2",  3'b000, 32'h80000002, 32'hFFFFFFF4);
        load("lbu2", 3'b100, 32'h80000002, 32'h000000F4);
        load("lh2",  3'b001, 32'h80000002, 32'h000012F4);
        load("lw0",  3'b010, 32'h80000000, 32'h12F45678);
        load("lb1",  3'b000, 32'h80000001, 32'h00000056);
        load("lh0",  3'b001, 32'h80000000, 32'h00005678);
        load("lhu2", 3'b101, 32'h80000002, 32'h000012F4);
`ifndef LSU_ALIGN_CHECK_EN
        store("sh3", 1'b0, 3'b001, 32'h80000003, 32'h00001234, 8'h08, 32'h34000000);
        load("lh3",  3'b001, 32'h80000003, 32'h00000012);
`endif

        // pass-through held while WBU stalls
        drive(1'b0, 1'b0, 3'b000, 32'h00000055, 32'h0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("pt.valid",   {31'h0, bus.out_valid}, 32'h1);
            chk("pt.result",  bus.out_result, 32'h00000055);
            chk("pt.ready",   {31'h0, bus.in_ready}, 32'h0);
            chk("pt.strobes", {30'h0, bus.Mem_Write, bus.Mem_Read}, 32'h0);
            chk("pt.reg_wen", {31'h0, bus.out_reg_wen}, 32'h1);
            tick();
        end
        retire("pt");

`ifdef LSU_ALIGN_CHECK_EN
        drive(1'b1, 1'b0, 3'b010, 32'h80000002, 32'h0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("mis.valid",   {31'h0, bus.out_valid}, 32'h1);
        chk("mis.fault",   {31'h0, bus.out_fault}, 32'h1);
        chk("mis.result",  bus.out_result, 32'h80000002);
        chk("mis.reg_wen", {31'h0, bus.out_reg_wen}, 32'h0);
        chk("mis.strobes", {30'h0, bus.Mem_Write, bus.Mem_Read}, 32'h0);
        retire("mis");
`endif

        // MEM_LAT=3: strobe at accept+4, result at +5
        bus3.in_valid = 1'b1; bus3.in_mem_read = 1'b1; bus3.in_func3 = 3'b010;
        bus3.in_addr = 32'h80000010; bus3.in_reg_wen = 1'b1;
        tick();
        bus3.in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk("lat3.rd_early", {31'h0, bus3.Mem_Read}, 32'h0);
            tick();
        end
        chk("lat3.rd+4",    {31'h0, bus3.Mem_Read}, 32'h1);
        tick();
        chk("lat3.valid+5", {31'h0, bus3.out_valid}, 32'h1);
        chk("lat3.result",  bus3.out_result, 32'h12F45678);
        bus3.out_ready = 1'b1;
        tick();
        bus3.out_ready = 1'b0;

        // reset arriving in the middle of WAIT
        bus3.in_valid = 1'b1;
        tick();
        bus3.in_valid = 1'b0;
        tick();
        rst3_n = 1'b0;
        #2;
        chk("wrst.ready", {31'h0, bus3.in_ready}, 32'h1);
        chk("wrst.valid", {31'h0, bus3.out_valid}, 32'h0);
        tick();
        rst3_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("wrst.strobes", {30'h0, bus3.Mem_Write, bus3.Mem_Read}, 32'h0);
            chk("wrst.valid_after", {31'h0, bus3.out_valid}, 32'h0);
            tick();
        end
        chk("wrst.ready_after", {31'h0, bus3.in_ready}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
